// File: rtl/color_period_meter_pkg.sv
// Shared types for the colour-sensor period meter: channel enum, filter-select codes, FSM states.
package color_period_meter_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2,
        CLEAR = 2'd3
    } chan_e;

    // Filter select codes driven on {S2,S3}
    localparam logic [1:0] CS_RED   = 2'b00;
    localparam logic [1:0] CS_GREEN = 2'b11;
    localparam logic [1:0] CS_BLUE  = 2'b01;
    localparam logic [1:0] CS_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ARM,
        ST_MEASURE,
        ST_REPORT
    } state_e;

    function automatic logic [1:0] cs_of(input chan_e c);
        case (c)
            RED:     cs_of = CS_RED;
            GREEN:   cs_of = CS_GREEN;
            BLUE:    cs_of = CS_BLUE;
            default: cs_of = CS_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/color_period_meter_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for the sensor square wave.
// A rise on freq_i shows up as a one-cycle rise_o pulse three clocks later.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic freq_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic       rise_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], freq_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/color_period_meter.sv
// Cycles the sensor filters red/green/blue/clear and reports the freq period per channel.
// Optional macro COLOR_AVG_EN: each report is the mean of 4 consecutive periods.
module color_period_meter
    import color_period_meter_pkg::*;
#(
    parameter int PW      = 19,
    parameter int SETTLE  = 50000,
    parameter int MAX_CNT = 500000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          freq,
    output logic [1:0]    CS,
    output logic [PW-1:0] period,
    output logic [1:0]    chan,
    output logic          valid,
    output logic          timeout,
    output logic          diode_change
);

    localparam logic [PW-1:0] SETTLE_C = PW'(SETTLE);
    localparam logic [PW-1:0] MAX_C    = PW'(MAX_CNT);
    localparam logic [PW-1:0] ONE      = PW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d, cnt_inc;
    chan_e         ch_q, ch_d, nxt_ch;
    chan_e         pchan_q, pchan_d;
    logic [1:0]    cs_q, cs_d;
    logic [PW-1:0] period_q, period_d;
    logic          to_q, to_d;
    logic          rise;
`ifdef COLOR_AVG_EN
    logic [PW+1:0] acc_q, acc_d, sum;
    logic [1:0]    nper_q, nper_d;
`endif

    edge_sync u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .freq_i (freq),
        .rise_o (rise)
    );

    // cnt_q holds the cycles elapsed since the reference point of the current state
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
    assign nxt_ch  = chan_e'(ch_q + 2'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        cs_d     = cs_q;
        period_d = period_q;
        pchan_d  = pchan_q;
        to_d     = to_q;
`ifdef COLOR_AVG_EN
        acc_d    = acc_q;
        nper_d   = nper_q;
        sum      = acc_q + (PW+2)'(cnt_q);
`endif
        if (!enable && state_q != ST_REPORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = ONE;
                    ch_d    = RED;
                    cs_d    = CS_RED;
                end
                ST_SETTLE: begin
                    if (cnt_q >= SETTLE_C) begin
                        state_d = ST_ARM;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = ONE;
`ifdef COLOR_AVG_EN
                        acc_d   = '0;
                        nper_d  = 2'd0;
`endif
                    end else if (cnt_q >= MAX_C) begin
                        state_d  = ST_REPORT;
                        period_d = '1;
                        to_d     = 1'b1;
                        pchan_d  = ch_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_MEASURE: begin
                    // An edge in the timeout cycle takes priority over the timeout
                    if (rise) begin
`ifdef COLOR_AVG_EN
                        if (nper_q == 2'd3) begin
                            state_d  = ST_REPORT;
                            period_d = sum[PW+1:2];
                            to_d     = 1'b0;
                            pchan_d  = ch_q;
                        end else begin
                            acc_d  = sum;
                            nper_d = nper_q + 2'd1;
                            cnt_d  = ONE;
                        end
`else
                        state_d  = ST_REPORT;
                        period_d = cnt_q;
                        to_d     = 1'b0;
                        pchan_d  = ch_q;
`endif
                    end else if (cnt_q >= MAX_C) begin
                        state_d  = ST_REPORT;
                        period_d = '1;
                        to_d     = 1'b1;
                        pchan_d  = ch_q;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_REPORT: begin
                    state_d = ST_SETTLE;
                    cnt_d   = ONE;
                    ch_d    = nxt_ch;
                    cs_d    = cs_of(nxt_ch);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ch_q     <= RED;
            cs_q     <= CS_RED;
            period_q <= '0;
            pchan_q  <= RED;
            to_q     <= 1'b0;
`ifdef COLOR_AVG_EN
            acc_q    <= '0;
            nper_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            cs_q     <= cs_d;
            period_q <= period_d;
            pchan_q  <= pchan_d;
            to_q     <= to_d;
`ifdef COLOR_AVG_EN
            acc_q    <= acc_d;
            nper_q   <= nper_d;
`endif
        end
    end

    assign CS      = cs_q;
    assign period  = period_q;
    assign chan    = pchan_q;
    assign valid   = (state_q == ST_REPORT);
    assign timeout = (state_q == ST_REPORT) & to_q;
    // A restart from a non-red filter also changes CS, so it is flagged too
    assign diode_change = (state_q == ST_REPORT) |
                          ((state_q == ST_IDLE) & enable & (cs_q != CS_RED));

endmodule

// File: tb/tb_color_period_meter.sv
// Self-checking bench for color_period_meter: vector table, randomized periods, corner sequences.
module tb_color_period_meter;

    localparam int PW   = 12;
    localparam int SET  = 20;
    localparam int MAXC = 1200;
    localparam logic [PW-1:0] ALL1 = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          freq;
    logic [1:0]    CS;
    logic [PW-1:0] period;
    logic [1:0]    chan;
    logic          valid;
    logic          timeout;
    logic          diode_change;

    color_period_meter #(.PW(PW), .SETTLE(SET), .MAX_CNT(MAXC)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .freq         (freq),
        .CS           (CS),
        .period       (period),
        .chan         (chan),
        .valid        (valid),
        .timeout      (timeout),
        .diode_change (diode_change)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;
    int n_valid = 0;
    int n_dc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid)        n_valid++;
            if (diode_change) n_dc++;
        end
    end

    // Square-wave source: rising edges spaced by seq[0..3] clk cycles in rotation, high for fhi cycles
    int seq[4] = '{0, 0, 0, 0};
    int fhi      = 0;
    int gen_ver  = 0;
    int ph       = 0;
    int idx      = 0;
    int seen_ver = -1;

    initial begin
        freq = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gen_ver != seen_ver) begin
                seen_ver = gen_ver;
                ph  = 0;
                idx = 0;
            end else if (seq[idx] > 0) begin
                ph++;
                if (ph >= seq[idx]) begin
                    ph  = 0;
                    idx = (idx + 1) % 4;
                end
            end
            freq = (seq[idx] > 0) && (ph < fhi);
        end
    end

    function automatic logic [1:0] cs_code(input int c);
        case (c)
            0:       cs_code = 2'b00;
            1:       cs_code = 2'b11;
            2:       cs_code = 2'b01;
            default: cs_code = 2'b10;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic start(input int s0, input int s1, input int s2, input int s3, input int hi);
        enable = 1'b0;
        seq    = '{s0, s1, s2, s3};
        fhi    = hi;
        gen_ver++;
        repeat (10) @(posedge clk);
        #1 enable = 1'b1;
    endtask

    // Constant period p: every report carries ep/eto, channels walk red..clear with matching CS
    task automatic run_const(input string nm, input int p, input int hi, input int nrep,
                             input logic [PW-1:0] ep, input bit eto);
        bit got;
        int last;
        start(p, p, p, p, hi);
        @(posedge clk);
        #1 mon_en = 1'b1;
        last = -1;
        for (int c = 0; c < nrep; c++) begin
            wait_valid(8000, got);
            if (!got) begin
                chk({nm, "_valid_seen"}, 32'd0, 32'd1);
                break;
            end
            chk({nm, "_chan"}, chan, c);
            chk({nm, "_period"}, period, ep);
            chk({nm, "_timeout"}, timeout, eto);
            chk({nm, "_cs"}, CS, cs_code(c));
            chk({nm, "_diode_change"}, diode_change, 32'd1);
            if (last >= 0) chk({nm, "_settle_gap"}, (cyc - last) > SET + 1, 32'd1);
            last = cyc;
        end
        #6 mon_en = 1'b0;
    endtask

    typedef struct {
        int            per;
        int            hi;
        int            nrep;
        logic [PW-1:0] ep;
        bit            eto;
    } vec_t;

    vec_t tbl[5];
    bit   got;
    int   cnt;
    int   rp;
    int   rh;

    initial begin
        tbl[0] = '{per: 1000,     hi: 500, nrep: 4, ep: PW'(1000), eto: 1'b0};
        tbl[1] = '{per: 0,        hi: 0,   nrep: 4, ep: ALL1,      eto: 1'b1};
        tbl[2] = '{per: MAXC,     hi: 1,   nrep: 2, ep: PW'(MAXC), eto: 1'b0};
        tbl[3] = '{per: MAXC + 1, hi: 600, nrep: 2, ep: ALL1,      eto: 1'b1};
        tbl[4] = '{per: 3,        hi: 1,   nrep: 4, ep: PW'(3),    eto: 1'b0};

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", CS, 32'd0);
        chk("rst_chan", chan, 32'd0);
        chk("rst_period", period, 32'd0);
        chk("rst_valid", valid, 32'd0);
        chk("rst_timeout", timeout, 32'd0);
        chk("rst_diode_change", diode_change, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_const("tbl", tbl[i].per, tbl[i].hi, tbl[i].nrep, tbl[i].ep, tbl[i].eto);
        end

        for (int t = 0; t < 4; t++) begin
            rp = $urandom_range(200, 2);
            rh = $urandom_range(rp - 1, 1);
            run_const("rnd", rp, rh, 4, PW'(rp), 1'b0);
        end

        chk("dc_vs_valid_count", n_dc, n_valid);

        // Rotating periods 1000..1003: any four consecutive sum to 4006
        start(1000, 1001, 1002, 1003, 500);
        for (int r = 0; r < 2; r++) begin
            wait_valid(8000, got);
            if (!got) begin
                chk("seq_valid_seen", 32'd0, 32'd1);
                break;
            end
`ifdef COLOR_AVG_EN
            chk("avg_period", period, 32'd1001);
`else
            chk("seq_period_range", (period >= 1000) && (period <= 1003), 32'd1);
`endif
            chk("seq_timeout", timeout, 32'd0);
        end

        // Enable dropped in the middle of the green measurement
        start(300, 300, 300, 300, 150);
        wait_valid(8000, got);
        chk("abort_first_valid", got, 32'd1);
        chk("abort_first_chan", chan, 32'd0);
        repeat (450) @(posedge clk);
        #1 enable = 1'b0;
        cnt = 0;
        repeat (800) begin
            @(posedge clk);
            #1;
            if (valid) cnt++;
        end
        chk("abort_no_valid", cnt, 32'd0);
        chk("abort_cs_kept", CS, 32'b11);
        enable = 1'b1;
        #1 chk("restart_diode_change", diode_change, 32'd1);
        @(posedge clk);
        #1 chk("restart_cs_red", CS, 32'd0);
        wait_valid(8000, got);
        chk("restart_valid", got, 32'd1);
        chk("restart_chan", chan, 32'd0);

        // Asynchronous reset between clock edges while measuring blue
        start(200, 200, 200, 200, 100);
        wait_valid(8000, got);
        wait_valid(8000, got);
        chk("areset_pre_chan", chan, 32'd1);
        repeat (250) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_cs", CS, 32'd0);
        chk("areset_chan", chan, 32'd0);
        chk("areset_period", period, 32'd0);
        chk("areset_valid", valid, 32'd0);
        chk("areset_timeout", timeout, 32'd0);
        chk("areset_diode_change", diode_change, 32'd0);
        #3 reset = 1'b0;
        wait_valid(8000, got);
        chk("areset_restart_valid", got, 32'd1);
        chk("areset_restart_chan", chan, 32'd0);
        chk("areset_restart_period", period, 32'd200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/color_period_meter.md
COLOR_PERIOD_METER -- requirements
Module: color_period_meter

Interface
REQ-001 SHALL have parameter PW, default 19, meaning width of the period and counter paths.
REQ-002 SHALL have parameter SETTLE, default 50000, meaning clk cycles to wait after each filter change.
REQ-003 SHALL have parameter MAX_CNT, default 500000, meaning clk cycles without an edge before timeout.
REQ-004 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, level; measurement runs while it is high.
REQ-007 SHALL have port freq, input, 1, asynchronous square wave from the colour sensor.
REQ-008 SHALL have port CS, output, 2, photodiode filter select (S2,S3).
REQ-009 SHALL have port period, output, PW, measured period in clk cycles, held until next valid.
REQ-010 SHALL have port chan, output, 2, channel of period: 0=red, 1=green, 2=blue, 3=clear.
REQ-011 SHALL have port valid, output, 1, one-cycle strobe marking new period/chan.
REQ-012 SHALL have port timeout, output, 1, qualifies valid: no edge within MAX_CNT.
REQ-013 SHALL have port diode_change, output, 1, one-cycle strobe when CS changes.

Function
REQ-014 SHALL pass freq through a 2-flop synchroniser, then detect rising edges; edge latency is 3 clk.
REQ-015 SHALL drive CS per channel: red=00, green=11, blue=01, clear=10.
REQ-016 SHALL visit channels in the order red, green, blue, clear, red, and so on.
REQ-017 SHALL implement FSM states IDLE, SETTLE, ARM, MEASURE and REPORT.
REQ-018 IDLE SHALL move to SETTLE when enable=1; SETTLE SHALL move to ARM after exactly SETTLE cycles.
REQ-019 ARM SHALL wait for the first rising edge, then clear the counter and enter MEASURE.
REQ-020 MEASURE SHALL count clk cycles between consecutive rising edges.
REQ-021 On the edge ending the last required period, MEASURE SHALL enter REPORT.
REQ-022 REPORT SHALL, for one cycle, assert valid, update period and chan, and load the next CS.
REQ-023 The cycle that loads the next CS SHALL also assert diode_change and return to SETTLE.
REQ-024 If an edge arrives at count c, the reported period SHALL be c: the edge-to-edge distance in clk cycles.
REQ-025 If ARM or MEASURE reaches MAX_CNT cycles without an edge, the block SHALL report period=all-ones with timeout=1, then advance the channel.
REQ-026 Counters SHALL saturate and never wrap.
REQ-027 enable falling SHALL abort at once to IDLE with no valid; CS is retained.
REQ-028 enable rising again SHALL restart at red.
REQ-029 If enable falls in the REPORT cycle, that report SHALL still complete.
REQ-030 An edge coinciding with the timeout cycle SHALL count as an edge; the edge wins.

Reset
REQ-031 On reset=1, outputs SHALL immediately be: CS=00, chan=0, period=0, valid=0, timeout=0, diode_change=0, FSM=IDLE.
REQ-032 Synchroniser flops and accumulators SHALL clear on reset.
REQ-033 Reset deasserted mid-measurement SHALL restart from IDLE at red.

Configuration
REQ-034 Macro COLOR_AVG_EN, when defined, SHALL make each report the sum of 4 consecutive periods shifted right 2, truncated.
REQ-035 With COLOR_AVG_EN, the accumulator SHALL be PW+2 bits wide.
REQ-036 With COLOR_AVG_EN, timeout SHALL apply to each single period.
REQ-037 Without COLOR_AVG_EN, each report SHALL be one period and the accumulator logic SHALL be absent.

Structure
REQ-038 A shared package SHALL hold the channel enum (RED, GREEN, BLUE, CLEAR), the CS code constants and the FSM state typedef.
REQ-039 Sub-module edge_sync SHALL contain the 2-flop synchroniser and rising-edge detector; all other logic SHALL be in color_period_meter.

Verification
REQ-040 Scenario: freq period 1000 clk, enable=1 -> valid chan=0 with period=1000, then chan=1,2,3 with CS 00,11,01,10.
REQ-041 Scenario: freq held low, MAX_CNT=500000 -> valid with timeout=1 and period=all-ones after 500000 cycles in ARM, then CS advances.
REQ-042 Scenario: enable dropped mid-MEASURE -> no valid, state IDLE; re-enable -> first report chan=0.
REQ-043 Scenario: reset pulsed asynchronously between clk edges during MEASURE -> all outputs at reset values before the next clk edge.
REQ-044 Scenario: COLOR_AVG_EN, periods 1000,1001,1002,1003 -> period=1001.
REQ-045 Scenario: diode_change count -> equals valid count; each diode_change is SETTLE+ cycles before the next ARM edge is accepted.
